// File: rtl/virtual_ds2431_rom_read_rom.sv
// Read ROM (0x33) executor: streams the 64-bit ROM ID LSB-first, one byte per
// transmitter handshake, then holds cmdDone until the dispatcher releases it.
module virtual_ds2431_rom_read_rom (
   input  logic        clk,
   input  logic        nRst,
   input  logic [63:0] romID,
   input  logic        cmdRunTrig,
   output logic [7:0]  sentDat,
   output logic        transTrig,
   input  logic        ByteTransDone,
   output logic        cmdDone
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] shift_q, shift_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  sent_dat_q, sent_dat_d;
   logic        trans_trig_q, trans_trig_d;
   logic        cmd_done_q, cmd_done_d;
   logic        btd_prev_q, btd_prev_d;
   logic        done_edge;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      sent_dat_d   = sent_dat_q;
      trans_trig_d = 1'b0;
      cmd_done_d   = cmd_done_q;
      btd_prev_d   = ByteTransDone;
      done_edge    = ByteTransDone & ~btd_prev_q;

      // The byte for SEND is registered on entry so it is visible during SEND;
      // the ID register rotates so its low byte always tracks the byte on the wire.
      unique case (state_q)
         IDLE: begin
            sent_dat_d = '0;
            cmd_done_d = 1'b0;
            idx_d      = '0;
            if (cmdRunTrig) begin
               shift_d      = romID;
               sent_dat_d   = romID[7:0];
               trans_trig_d = 1'b1;
               state_d      = SEND;
            end
         end
         SEND: begin
            if (!cmdRunTrig) begin
               state_d    = IDLE;
               idx_d      = '0;
               sent_dat_d = '0;
               cmd_done_d = 1'b0;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!cmdRunTrig) begin
               state_d    = IDLE;
               idx_d      = '0;
               sent_dat_d = '0;
               cmd_done_d = 1'b0;
            end else if (done_edge) begin
               if (idx_q != 3'd7) begin
                  shift_d      = {shift_q[7:0], shift_q[63:8]};
                  sent_dat_d   = shift_q[15:8];
                  trans_trig_d = 1'b1;
                  idx_d        = idx_q + 3'd1;
                  state_d      = SEND;
               end else begin
                  cmd_done_d = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            if (!cmdRunTrig) begin
               state_d    = IDLE;
               idx_d      = '0;
               sent_dat_d = '0;
               cmd_done_d = 1'b0;
            end else begin
               cmd_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Edge-detect history resets high so an idle-high done level never counts.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         idx_q        <= '0;
         sent_dat_q   <= '0;
         trans_trig_q <= 1'b0;
         cmd_done_q   <= 1'b0;
         btd_prev_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         sent_dat_q   <= sent_dat_d;
         trans_trig_q <= trans_trig_d;
         cmd_done_q   <= cmd_done_d;
         btd_prev_q   <= btd_prev_d;
      end
   end

   assign sentDat   = sent_dat_q;
   assign transTrig = trans_trig_q;
   assign cmdDone   = cmd_done_q;

endmodule

// File: tb/tb_virtual_ds2431_rom_read_rom.sv
// Randomized bench for the Read ROM executor: a byte-count reference model
// predicts every output each cycle, with literal checks on the known ROM ID.
module tb_virtual_ds2431_rom_read_rom;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic [63:0] romID = 64'h0;
   logic        cmdRunTrig = 1'b0;
   logic        ByteTransDone = 1'b1;
   logic [7:0]  sentDat;
   logic        transTrig;
   logic        cmdDone;

   int checks = 0;
   int errors = 0;

   virtual_ds2431_rom_read_rom dut (
      .clk(clk),
      .nRst(nRst),
      .romID(romID),
      .cmdRunTrig(cmdRunTrig),
      .sentDat(sentDat),
      .transTrig(transTrig),
      .ByteTransDone(ByteTransDone),
      .cmdDone(cmdDone)
   );

   always #10 clk = ~clk;

   localparam logic [63:0] KNOWN_ID = 64'hc500002c40e4d42d;
   logic [7:0] known_bytes [8] = '{8'h2d, 8'hd4, 8'he4, 8'h40, 8'h2c, 8'h00, 8'h00, 8'hc5};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks how many bytes have been issued for the current
   // command and what the outputs must be in the following cycle.
   bit          m_busy = 0;
   bit          m_done = 0;
   bit          m_trig = 0;
   bit          m_prev_btd = 1;
   int          m_issued = 0;
   logic [63:0] m_id = '0;
   logic [7:0]  m_dat = '0;

   initial forever begin
      @(posedge clk or negedge nRst);
      if (!nRst) begin
         m_busy = 0; m_done = 0; m_trig = 0; m_prev_btd = 1;
         m_issued = 0; m_dat = '0;
      end else begin
         bit rise;
         rise = ByteTransDone && !m_prev_btd;
         m_prev_btd = ByteTransDone;
         if (m_busy) begin
            if (!cmdRunTrig) begin
               m_busy = 0; m_issued = 0; m_trig = 0; m_dat = '0;
            end else if (m_trig) begin
               m_trig = 0;
            end else if (rise) begin
               if (m_issued < 8) begin
                  m_dat = 8'((m_id >> (8 * m_issued)) & 64'hff);
                  m_issued++;
                  m_trig = 1;
               end else begin
                  m_busy = 0; m_done = 1;
               end
            end
         end else if (m_done) begin
            if (!cmdRunTrig) begin
               m_done = 0; m_dat = '0; m_issued = 0;
            end
         end else begin
            m_dat = '0; m_trig = 0;
            if (cmdRunTrig) begin
               m_busy = 1; m_id = romID; m_issued = 1;
               m_dat = romID[7:0]; m_trig = 1;
            end
         end
      end
   end

   int         pulses = 0;
   logic [7:0] cap [$];

   initial forever begin
      @(negedge clk);
      chk("sentDat", sentDat, m_dat);
      chk("transTrig", transTrig, m_trig);
      chk("cmdDone", cmdDone, m_done);
      if (transTrig === 1'b1) begin
         pulses++;
         cap.push_back(sentDat);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_trig(output bit ok);
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (transTrig === 1'b1) begin
            ok = 1;
            break;
         end
         step(1);
      end
      chk("trig_timeout", ok, 1);
   endtask

   task automatic serve_byte(input int gap, input bit one_cycle);
      step(2);
      ByteTransDone = 1'b0;
      step(gap);
      ByteTransDone = 1'b1;
      if (one_cycle) begin
         step(1);
         ByteTransDone = 1'b0;
      end
   endtask

   task automatic run_bytes(input int n);
      bit ok;
      for (int k = 0; k < n; k++) begin
         wait_trig(ok);
         if (!ok) return;
         serve_byte(int'($urandom_range(3, 9)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      bit ok;
      // Reset and quiet release
      step(3);
      chk("rst_sentDat", sentDat, 8'h00);
      chk("rst_transTrig", transTrig, 0);
      chk("rst_cmdDone", cmdDone, 0);
      nRst = 1'b1;
      step(5);
      chk("idle_sentDat", sentDat, 8'h00);
      chk("idle_cmdDone", cmdDone, 0);

      // Full command with the known ID
      romID = KNOWN_ID;
      pulses = 0; cap.delete();
      cmdRunTrig = 1'b1;
      run_bytes(8);
      step(3);
      chk("full_done_set", cmdDone, 1);
      step(25);
      chk("full_done_held", cmdDone, 1);
      cmdRunTrig = 1'b0;
      step(1);
      chk("full_done_clear", cmdDone, 0);
      chk("full_pulses", pulses, 8);
      for (int i = 0; i < 8; i++)
         if (i < cap.size()) chk("full_byte", cap[i], known_bytes[i]);

      // Idle-high done level must not advance the transfer
      ByteTransDone = 1'b1;
      step(2);
      pulses = 0;
      cmdRunTrig = 1'b1;
      step(20);
      chk("idlehigh_pulses", pulses, 1);
      ByteTransDone = 1'b0;
      step(1);
      ByteTransDone = 1'b1;
      step(3);
      chk("idlehigh_after_edge", pulses, 2);
      cmdRunTrig = 1'b0;
      step(2);

      // Repeat command restarts at byte 0
      romID = KNOWN_ID;
      cap.delete();
      cmdRunTrig = 1'b1;
      run_bytes(8);
      step(2);
      chk("repeat_first", cap.size() > 0 ? cap[0] : 8'hxx, 8'h2d);
      cmdRunTrig = 1'b0;
      step(2);

      // Asynchronous reset mid-transfer
      ByteTransDone = 1'b1;
      step(1);
      cmdRunTrig = 1'b1;
      run_bytes(3);
      @(posedge clk);
      #5 nRst = 1'b0;
      #1;
      chk("midrst_sentDat", sentDat, 8'h00);
      chk("midrst_transTrig", transTrig, 0);
      chk("midrst_cmdDone", cmdDone, 0);
      step(2);
      ByteTransDone = 1'b1;
      nRst = 1'b1;
      wait_trig(ok);
      chk("midrst_restart_byte", sentDat, 8'h2d);
      chk("midrst_no_done", cmdDone, 0);
      cmdRunTrig = 1'b0;
      step(2);

      // Abort while waiting on byte 4
      ByteTransDone = 1'b1;
      romID = {$urandom, $urandom};
      step(1);
      cmdRunTrig = 1'b1;
      run_bytes(3);
      wait_trig(ok);
      step(3);
      cmdRunTrig = 1'b0;
      pulses = 0;
      step(2);
      ByteTransDone = 1'b0;
      step(2);
      ByteTransDone = 1'b1;
      step(20);
      chk("abort_pulses", pulses, 0);
      chk("abort_done", cmdDone, 0);

      // Randomized commands, including aborts, SEND-cycle aborts and ID churn
      for (int it = 0; it < 12; it++) begin
         int nb;
         romID = {$urandom, $urandom};
         ByteTransDone = 1'($urandom_range(0, 1));
         step(int'($urandom_range(1, 3)));
         cmdRunTrig = 1'b1;
         nb = int'($urandom_range(1, 8));
         for (int k = 0; k < nb; k++) begin
            wait_trig(ok);
            if (!ok) break;
            if ($urandom_range(0, 3) == 0) romID = {$urandom, $urandom};
            if (nb < 8 && k == nb - 1 && $urandom_range(0, 1) == 1) break;
            serve_byte(int'($urandom_range(2, 8)), 1'($urandom_range(0, 1)));
         end
         step(int'($urandom_range(1, 12)));
         cmdRunTrig = 1'b0;
         step(int'($urandom_range(1, 3)));
      end

      step(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
